diver_controller: RTL and testbench

Upstream stage of the bottle collectable and the hazard controllers. Turns debounced player buttons into the diver's top-left screen position (d_x, d_y) plus facing and motion status. Models underwater motion: horizontal swim at fixed speed, accelerating rise while "up" is held, slow drift-sink otherwise, rest on the sea floor. Position only updates on frame ticks, so every consumer sees one stable position per frame.

---
 rtl/diver_pkg.sv | 19 +
 rtl/diver_controller_if.sv | 28 ++
 rtl/diver_controller_sat_step.sv | 36 +++
 rtl/diver_controller.sv | 140 ++++++++++++++
 tb/tb_diver_controller.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/diver_pkg.sv
// Shared definitions for the diver controller and its downstream consumers
// (bottle collectable and hazard controllers).
// Contents: sprite size used for collision boxes, coordinate type and the
// vertical motion state encoding.
package diver_pkg;

  localparam int COORD_W = 10;
  localparam int DIVER_W = 16;
  localparam int DIVER_H = 18;

  typedef logic [COORD_W-1:0] coord_t;

  typedef enum logic [1:0] {
    REST = 2'd0,
    RISE = 2'd1,
    SINK = 2'd2
  } mstate_e;

endpackage

// File: rtl/diver_controller_if.sv
// Player-input / diver-position bundle.
// master: drives tick and debounced buttons, observes position and status.
// slave : the diver controller; consumes tick/buttons, drives d_x, d_y,
//         facing, mstate, at_floor.
interface diver_controller_if;
  import diver_pkg::*;

  logic       tick;
  logic       btn_l;
  logic       btn_r;
  logic       btn_u;
  coord_t     d_x;
  coord_t     d_y;
  logic       facing;
  logic [1:0] mstate;
  logic       at_floor;

  modport master (
    output tick, btn_l, btn_r, btn_u,
    input  d_x, d_y, facing, mstate, at_floor
  );

  modport slave (
    input  tick, btn_l, btn_r, btn_u,
    output d_x, d_y, facing, mstate, at_floor
  );

endinterface

// File: rtl/diver_controller_sat_step.sv
// sat_step: one-step coordinate update with clamping.
// Computes i_val +/- i_mag one bit wider than a coordinate and signed, so a
// step below zero is seen as negative instead of wrapping, then clamps the
// result into the inclusive range [i_lo, i_hi].
// Ports: i_val (current coordinate), i_mag (step size), i_sub (1 = subtract),
//        i_lo/i_hi (inclusive bounds), o_val (clamped result).
module sat_step
  import diver_pkg::*;
(
  input  coord_t i_val,
  input  coord_t i_mag,
  input  logic   i_sub,
  input  coord_t i_lo,
  input  coord_t i_hi,
  output coord_t o_val
);

  logic signed [COORD_W:0] w_sum;

  function automatic coord_t clamp(input logic signed [COORD_W:0] v,
                                   input coord_t lo, input coord_t hi);
    coord_t res;
    if (v < $signed({1'b0, lo}))      res = lo;
    else if (v > $signed({1'b0, hi})) res = hi;
    else                              res = v[COORD_W-1:0];
    return res;
  endfunction

  always_comb begin
    if (i_sub) w_sum = $signed({1'b0, i_val}) - $signed({1'b0, i_mag});
    else       w_sum = $signed({1'b0, i_val}) + $signed({1'b0, i_mag});
  end

  assign o_val = clamp(w_sum, i_lo, i_hi);

endmodule

// File: rtl/diver_controller.sv
// diver_controller: turns debounced buttons into the diver's top-left screen
// position plus facing and vertical motion status. All state advances only on
// frame ticks, so consumers see one stable position per frame.
// Ports: clk, rst (synchronous, active-high);
//        bus (slave): tick, btn_l, btn_r, btn_u in;
//                     d_x, d_y, facing, mstate, at_floor out (registered).
module diver_controller
  import diver_pkg::*;
#(
  parameter int X_INIT   = 100,
  parameter int X_MIN    = 8,
  parameter int X_MAX    = 632,
  parameter int Y_MIN    = 40,
  parameter int Y_MAX    = 472,
  parameter int X_SPEED  = 2,
  parameter int MAX_VY   = 4,
  parameter int SINK_DIV = 4
) (
  input  logic               clk,
  input  logic               rst,
  diver_controller_if.slave  bus
);

  localparam coord_t X_LO    = coord_t'(X_MIN);
  localparam coord_t X_HI    = coord_t'(X_MAX - DIVER_W);
  localparam coord_t Y_LO    = coord_t'(Y_MIN);
  localparam coord_t Y_FLOOR = coord_t'(Y_MAX - DIVER_H);
  localparam int     VY_W    = $clog2(MAX_VY + 1);
  localparam int     CNT_W   = (SINK_DIV > 1) ? $clog2(SINK_DIV) : 1;

  coord_t           r_x, r_y;
  logic             r_facing;
  mstate_e          r_state;
  logic [VY_W-1:0]  r_vy;
  logic [CNT_W-1:0] r_cnt;
  logic             r_at_floor;

  coord_t           w_x_nxt, w_y_nxt, w_x_step, w_y_step;
  logic             w_facing_nxt;
  mstate_e          w_state_nxt;
  logic [VY_W-1:0]  w_vy_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_move_l, w_move_r;

  assign w_move_l = bus.btn_l & ~bus.btn_r;
  assign w_move_r = bus.btn_r & ~bus.btn_l;

  sat_step u_step_x (
    .i_val (r_x),
    .i_mag (coord_t'(X_SPEED)),
    .i_sub (w_move_l),
    .i_lo  (X_LO),
    .i_hi  (X_HI),
    .o_val (w_x_step)
  );

  // Rising moves up by the current speed; sinking moves down one pixel.
  sat_step u_step_y (
    .i_val (r_y),
    .i_mag ((r_state == RISE) ? coord_t'(r_vy) : coord_t'(1)),
    .i_sub (r_state == RISE),
    .i_lo  (Y_LO),
    .i_hi  (Y_FLOOR),
    .o_val (w_y_step)
  );

  always_comb begin
    w_x_nxt      = r_x;
    w_y_nxt      = r_y;
    w_facing_nxt = r_facing;
    w_state_nxt  = r_state;
    w_vy_nxt     = r_vy;
    w_cnt_nxt    = r_cnt;

    if (w_move_l || w_move_r) begin
      w_x_nxt      = w_x_step;
      w_facing_nxt = w_move_r;
    end

    unique case (r_state)
      REST: begin
        if (bus.btn_u) begin
          w_state_nxt = RISE;
          w_vy_nxt    = VY_W'(1);
        end
      end
      RISE: begin
        if (!bus.btn_u) begin
          w_state_nxt = SINK;
          w_vy_nxt    = '0;
          w_cnt_nxt   = '0;
        end else begin
          w_y_nxt  = w_y_step;
          w_vy_nxt = (r_vy == VY_W'(MAX_VY)) ? r_vy : r_vy + VY_W'(1);
        end
      end
      SINK: begin
        if (bus.btn_u) begin
          w_state_nxt = RISE;
          w_vy_nxt    = VY_W'(1);
        end else if (r_cnt == CNT_W'(SINK_DIV - 1)) begin
          // One pixel of drift every SINK_DIV ticks; landing ends the sink.
          w_y_nxt   = w_y_step;
          w_cnt_nxt = '0;
          if (w_y_step == Y_FLOOR) w_state_nxt = REST;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: w_state_nxt = REST;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_x        <= coord_t'(X_INIT);
      r_y        <= Y_FLOOR;
      r_facing   <= 1'b1;
      r_state    <= REST;
      r_vy       <= '0;
      r_cnt      <= '0;
      r_at_floor <= 1'b1;
    end else if (bus.tick) begin
      r_x        <= w_x_nxt;
      r_y        <= w_y_nxt;
      r_facing   <= w_facing_nxt;
      r_state    <= w_state_nxt;
      r_vy       <= w_vy_nxt;
      r_cnt      <= w_cnt_nxt;
      r_at_floor <= (w_y_nxt == Y_FLOOR);
    end
  end

  assign bus.d_x      = r_x;
  assign bus.d_y      = r_y;
  assign bus.facing   = r_facing;
  assign bus.mstate   = r_state;
  assign bus.at_floor = r_at_floor;

endmodule

// File: tb/tb_diver_controller.sv
// Testbench for diver_controller: a table of hand-derived tick vectors, a few
// directed multi-cycle sequences (clamps, sink to floor, surface, reset
// mid-rise) and randomized stimulus compared against a behavioural model.
module tb_diver_controller;
  import diver_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  diver_controller_if bus ();

  diver_controller dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  // Behavioural model state: position, facing, state (0 rest,1 rise,2 sink),
  // rise speed and sink tick counter.
  int mx, my, mf, ms, mvy, mc;

  typedef struct {
    logic l, r, u;
    int   x, y, f, s;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic model_update(input logic rs, input logic t, input logic l,
                              input logic r, input logic u);
    if (rs) begin
      mx = 100; my = 454; mf = 1; ms = 0; mvy = 0; mc = 0;
    end else if (t) begin
      if (l && !r) begin
        mx = (mx - 2 < 8) ? 8 : mx - 2; mf = 0;
      end else if (r && !l) begin
        mx = (mx + 2 > 616) ? 616 : mx + 2; mf = 1;
      end
      if (ms == 0) begin
        if (u) begin ms = 1; mvy = 1; end
      end else if (ms == 1) begin
        if (!u) begin
          ms = 2; mvy = 0; mc = 0;
        end else begin
          my  = (my - mvy < 40) ? 40 : my - mvy;
          mvy = (mvy + 1 > 4) ? 4 : mvy + 1;
        end
      end else begin
        if (u) begin
          ms = 1; mvy = 1;
        end else if (mc == 3) begin
          my = (my + 1 > 454) ? 454 : my + 1;
          mc = 0;
          if (my == 454) ms = 0;
        end else begin
          mc++;
        end
      end
    end
  endtask

  task automatic step(input logic rs, input logic t, input logic l,
                      input logic r, input logic u);
    rst       = rs;
    bus.tick  = t;
    bus.btn_l = l;
    bus.btn_r = r;
    bus.btn_u = u;
    @(posedge clk);
    model_update(rs, t, l, r, u);
    #1;
  endtask

  task automatic check_model(input string tag);
    chk({tag, " d_x"}, int'(bus.d_x), mx);
    chk({tag, " d_y"}, int'(bus.d_y), my);
    chk({tag, " facing"}, int'(bus.facing), mf);
    chk({tag, " mstate"}, int'(bus.mstate), ms);
    chk({tag, " at_floor"}, int'(bus.at_floor), (my == 454) ? 1 : 0);
  endtask

  task automatic add(input logic l, input logic r, input logic u,
                     input int x, input int y, input int f, input int s);
    vec_t v;
    v.l = l; v.r = r; v.u = u; v.x = x; v.y = y; v.f = f; v.s = s;
    tbl.push_back(v);
  endtask

  initial begin
    int rise_y[6];
    int sink_y[9];
    rise_y = '{454, 453, 451, 448, 444, 440};
    sink_y = '{440, 440, 440, 440, 441, 441, 441, 441, 442};

    // Table: idle, swim right, both buttons, swim left, rise, drift-sink.
    for (int i = 0; i < 5; i++)  add(0, 0, 0, 100, 454, 1, 0);
    for (int i = 1; i <= 10; i++) add(0, 1, 0, 100 + 2 * i, 454, 1, 0);
    for (int i = 0; i < 3; i++)  add(1, 1, 0, 120, 454, 1, 0);
    add(1, 0, 0, 118, 454, 0, 0);
    for (int i = 0; i < 6; i++)  add(0, 0, 1, 118, rise_y[i], 0, 1);
    for (int i = 0; i < 9; i++)  add(0, 0, 0, 118, sink_y[i], 0, 2);

    step(1, 0, 0, 0, 0);
    chk("reset d_x", int'(bus.d_x), 100);
    chk("reset d_y", int'(bus.d_y), 454);
    chk("reset facing", int'(bus.facing), 1);
    chk("reset mstate", int'(bus.mstate), 0);
    chk("reset at_floor", int'(bus.at_floor), 1);

    foreach (tbl[i]) begin
      step(0, 1, tbl[i].l, tbl[i].r, tbl[i].u);
      chk($sformatf("vec%0d d_x", i), int'(bus.d_x), tbl[i].x);
      chk($sformatf("vec%0d d_y", i), int'(bus.d_y), tbl[i].y);
      chk($sformatf("vec%0d facing", i), int'(bus.facing), tbl[i].f);
      chk($sformatf("vec%0d mstate", i), int'(bus.mstate), tbl[i].s);
      chk($sformatf("vec%0d at_floor", i), int'(bus.at_floor),
          (tbl[i].y == 454) ? 1 : 0);
    end

    // No tick: buttons must be ignored.
    step(0, 0, 1, 0, 1);
    chk("notick d_x", int'(bus.d_x), 118);
    chk("notick mstate", int'(bus.mstate), 2);

    // Left clamp from 10, then right clamp from 614.
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 45; i++) step(0, 1, 1, 0, 0);
    chk("left to 10", int'(bus.d_x), 10);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 1, 0, 0);
      chk($sformatf("left clamp %0d", i), int'(bus.d_x), 8);
    end
    for (int i = 0; i < 303; i++) step(0, 1, 0, 1, 0);
    chk("right to 614", int'(bus.d_x), 614);
    for (int i = 0; i < 2; i++) begin
      step(0, 1, 0, 1, 0);
      chk($sformatf("right clamp %0d", i), int'(bus.d_x), 616);
    end
    chk("right clamp facing", int'(bus.facing), 1);

    // Sink from 452 back to the floor.
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 1);
    chk("pre-sink d_y", int'(bus.d_y), 451);
    step(0, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 0);
    chk("sink start d_y", int'(bus.d_y), 452);
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 0);
    chk("sink mid d_y", int'(bus.d_y), 453);
    chk("sink mid mstate", int'(bus.mstate), 2);
    chk("sink mid at_floor", int'(bus.at_floor), 0);
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 0);
    chk("sink land d_y", int'(bus.d_y), 454);
    chk("sink land mstate", int'(bus.mstate), 0);
    chk("sink land at_floor", int'(bus.at_floor), 1);

    // Rise to the surface and stay there.
    for (int k = 0; k < 200 && bus.d_y != 10'd40; k++) step(0, 1, 0, 0, 1);
    chk("surface reached", int'(bus.d_y), 40);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 0, 0, 1);
      chk($sformatf("surface hold d_y %0d", i), int'(bus.d_y), 40);
      chk($sformatf("surface hold mstate %0d", i), int'(bus.mstate), 1);
    end

    // Reset in the middle of a rise, with tick and buttons active.
    step(1, 0, 0, 0, 0);
    for (int k = 0; k < 100 && my != 200; k++) step(0, 1, 0, 1, 1);
    chk("midrise d_y", int'(bus.d_y), 200);
    chk("midrise mstate", int'(bus.mstate), 1);
    step(1, 1, 0, 1, 1);
    chk("rst midrise d_x", int'(bus.d_x), 100);
    chk("rst midrise d_y", int'(bus.d_y), 454);
    chk("rst midrise mstate", int'(bus.mstate), 0);
    chk("rst midrise at_floor", int'(bus.at_floor), 1);
    chk("rst midrise facing", int'(bus.facing), 1);
    step(0, 1, 0, 0, 1);
    chk("rerise first d_y", int'(bus.d_y), 454);
    step(0, 1, 0, 0, 1);
    chk("rerise vy restart d_y", int'(bus.d_y), 453);

    // Randomized run against the model.
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      logic rs, t, l, r, u;
      rs = ($urandom_range(0, 199) == 0);
      t  = ($urandom_range(0, 3) != 0);
      l  = ($urandom_range(0, 2) == 0);
      r  = ($urandom_range(0, 2) == 0);
      u  = ($urandom_range(0, 99) < 55);
      step(rs, t, l, r, u);
      check_model($sformatf("rand%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
